sobel_window_buffer: RTL
========================

// Module: sobel_window_buffer
// PURPOSE
//  Parametrised K x K sliding-window generator for raster-scan pixel streams. It is the
//  successor to the fixed 64-cell Enable-driven shift FIFO: it provides K-1 line delays of
//  IMG_W pixels, a K x K window register array, and row/column tracking with a window-valid
//  flag. It sits between the pixel source and the Sobel/convolution kernel.
// PARAMETERS
//  DATA_W  8   pixel width in bits
//  IMG_W   64  pixels per image line (line-delay depth), >= K
//  K       3   window size (K-1 line delays, K x K window), >= 2
//  ROW_W   16  row counter width
// PORTS
//  CLK          in   1              rising-edge clock
//  RST_n        in   1              asynchronous active-low reset
//  Enable       in   1              accept DataIn this cycle (one pixel per Enable cycle)
//  Clear        in   1              synchronous frame restart
//  DataIn       in   DATA_W         incoming pixel, raster order
//  Window       out  K*K*DATA_W     window; see BEHAVIOUR for packing
//  WindowValid  out  1              Window is a complete in-image window
//  Col          out  clog2(IMG_W)   column of the most recently accepted pixel
//  Row          out  ROW_W          row of the most recently accepted pixel
// BEHAVIOUR
//  - Reset (RST_n=0, any time, async): Window, WindowValid, Col, Row, internal counters
//    all 0. Line-delay contents need not be cleared.
//  - Accepted pixel = cycle with Enable=1 and Clear=0. Nothing changes on other cycles
//    except WindowValid, which drops to 0 (one-cycle pulse per accepted pixel).
//  - Line delay L (1..K-1) yields the pixel accepted exactly L*IMG_W accepted pixels
//    earlier. Implementation (shift chain or circular RAM + pointer) is free, but it must
//    advance only on accepted pixels.
//  - Latency 1: after accepting pixel P(r,c) at edge n, from edge n Window holds
//    Window[(i*K+j)*DATA_W +: DATA_W] = P(r-(K-1)+i, c-(K-1)+j), i,j in 0..K-1.
//    Top bits hold the newest pixel P(r,c).
//  - Col/Row update at the same edge to (c,r) of the accepted pixel. Col wraps
//    IMG_W-1 -> 0 and Row then increments. Row saturates at 2^ROW_W-1 (no wrap).
//  - WindowValid=1 for the cycle after an accepted pixel iff r>=K-1 and c>=K-1. Windows
//    straddling a line start contain previous-row data and are masked by this rule.
//  - Clear=1 (priority over Enable): Col/Row/pointers to the start-of-frame state,
//    WindowValid=0. DataIn is not accepted. Next accepted pixel is P(0,0).
//  - Invalid Window contents are don't-care. Line-delay data left over from before Clear or
//    reset must never appear with WindowValid=1.
//  - Back-to-back Enable: full throughput, 1 pixel/cycle, no stalls.
// TESTING
//  1 Reset: RST_n low mid-stream -> Window=0, WindowValid=0, Col=0, Row=0 immediately.
//  2 Ramp frame, default params, DataIn=(r*64+c)%256, Enable=1 continuous -> first
//    WindowValid after P(2,2). Window = {130,129,128,66,65,64,2,1,0} (MSB->LSB).
//    Check every valid window against the reference model.
//  3 Line wrap: at rows >= 2, WindowValid=0 after cols 0 and 1 and =1 after cols 2..63.
//    Col goes 63->0 with Row+1.
//  4 Enable gaps: random 30% Enable=0 bubbles during the ramp frame -> the same window
//    sequence as scenario 2. WindowValid is never high in a bubble-following cycle.
//  5 Clear mid-frame at P(10,20), then new frame of 0xFF -> WindowValid stays 0 until
//    P(2,2) of the new frame. All valid windows = 0xFF. Clear+Enable same cycle is ignored.
//  6 Params IMG_W=8, K=5, DATA_W=10 -> first valid after P(4,4). Window[0] = P(0,0).
//    The check of scenario 2 passes with the scaled model.

Source files
------------

// File: rtl/sobel_window_buffer.sv
// K x K sliding-window generator for raster-scan pixel streams: K-1 line delays of
// IMG_W pixels, a window register array, and row/column tracking with a valid flag.
module sobel_window_buffer #(
  parameter  int DATA_W = 8,
  parameter  int IMG_W  = 64,
  parameter  int K      = 3,
  parameter  int ROW_W  = 16,
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic                    Enable,
  input  logic                    Clear,
  input  logic [DATA_W-1:0]       DataIn,
  output logic [K*K*DATA_W-1:0]   Window,
  output logic                    WindowValid,
  output logic [COL_W-1:0]        Col,
  output logic [ROW_W-1:0]        Row
);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = {ROW_W{1'b1}};

  logic                    w_accept;
  logic [DATA_W-1:0]       w_colv [K];
  logic [COL_W-1:0]        r_col_nxt;
  logic [ROW_W-1:0]        r_row_nxt;
  logic [COL_W-1:0]        r_col;
  logic [ROW_W-1:0]        r_row;
  logic                    r_valid;
  logic [K*K*DATA_W-1:0]   r_win;
  logic [DATA_W-1:0]       r_line [K-1][IMG_W];

  // Incoming column: w_colv[L] is the pixel L lines above the one being accepted.
  always_comb begin
    w_accept  = Enable & ~Clear;
    w_colv[0] = DataIn;
    for (int l = 1; l < K; l++) begin
      w_colv[l] = r_line[l-1][r_col_nxt];
    end
  end

  // Raster position tracking and window-valid pulse.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_col_nxt <= '0;
      r_row_nxt <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_valid   <= 1'b0;
    end else if (Clear) begin
      r_col_nxt <= '0;
      r_row_nxt <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_valid   <= 1'b0;
    end else if (Enable) begin
      r_col   <= r_col_nxt;
      r_row   <= r_row_nxt;
      // Windows that straddle a line start or reach above row 0 are masked here.
      r_valid <= (r_row_nxt >= ROW_FIRST) && (r_col_nxt >= COL_FIRST);
      if (r_col_nxt == COL_LAST) begin
        r_col_nxt <= '0;
        if (r_row_nxt != ROW_MAX) begin
          r_row_nxt <= r_row_nxt + ROW_W'(1);
        end
      end else begin
        r_col_nxt <= r_col_nxt + COL_W'(1);
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Window array: each row shifts toward index 0, newest column enters at j = K-1.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_win <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          if (j < K - 1) begin
            r_win[(i*K+j)*DATA_W +: DATA_W] <= r_win[(i*K+j+1)*DATA_W +: DATA_W];
          end else begin
            r_win[(i*K+j)*DATA_W +: DATA_W] <= w_colv[K-1-i];
          end
        end
      end
    end
  end

  // Line delays as per-column RAMs; each cascades into the next on every accepted pixel.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_line[0][r_col_nxt] <= DataIn;
      for (int l = 1; l < K - 1; l++) begin
        r_line[l][r_col_nxt] <= r_line[l-1][r_col_nxt];
      end
    end
  end

  assign Window      = r_win;
  assign WindowValid = r_valid;
  assign Col         = r_col;
  assign Row         = r_row;

endmodule
